// File: rtl/sample_packer_pkg.sv
// sample_packer_pkg: widths, derived counts and output-FSM states
// shared by the sample packer and the output parser.
package sample_packer_pkg;

   localparam int SAMPLE_W    = 16;
   localparam int CHUNK_W     = 128;
   localparam int FRAME_BYTES = 256;
   localparam int LANES       = CHUNK_W / SAMPLE_W;
   localparam int CHUNKS      = FRAME_BYTES * 8 / CHUNK_W;

   typedef enum logic [1:0] {
      O_IDLE,
      O_OFFER,
      O_DRAIN
   } ofsm_e;

endpackage

// File: rtl/sample_packer_chunk_offer_fsm.sv
// chunk_offer_fsm: hold register and the offer/drain handshake
// towards the parser; pulses done when the last chunk drains.
module chunk_offer_fsm
   import sample_packer_pkg::*;
#(
   parameter int CHUNK_W = sample_packer_pkg::CHUNK_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [CHUNK_W-1:0] chunk_i,
   input  logic               last_i,
   input  logic               busy_i,
   output logic               hold_valid_o,
   output logic [CHUNK_W-1:0] data_o,
   output logic               ready_o,
   output logic               idle_o,
   output logic               done_o
);

   ofsm_e              state_q, state_d;
   logic [CHUNK_W-1:0] hold_q;
   logic               hold_last_q;
   logic               hold_valid_q, hold_valid_d;
   logic               done_q, done_d;
   logic               release_w;

   // The hold slot is reported free on the edge it drains so a
   // new chunk can be loaded in that same edge.
   assign release_w    = (state_q == O_DRAIN) && !busy_i;
   assign hold_valid_o = hold_valid_q && !release_w;

   always_comb begin
      state_d      = state_q;
      hold_valid_d = hold_valid_q;
      done_d       = 1'b0;
      unique case (state_q)
         O_IDLE: begin
            if (hold_valid_q) state_d = O_OFFER;
         end
         O_OFFER: begin
            if (busy_i) state_d = O_DRAIN;
         end
         O_DRAIN: begin
            if (!busy_i) begin
               state_d      = O_IDLE;
               hold_valid_d = 1'b0;
               done_d       = hold_last_q;
            end
         end
         default: state_d = O_IDLE;
      endcase
      if (load_i) hold_valid_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= O_IDLE;
         hold_q       <= '0;
         hold_last_q  <= 1'b0;
         hold_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_valid_q <= hold_valid_d;
         done_q       <= done_d;
         if (load_i) begin
            hold_q      <= chunk_i;
            hold_last_q <= last_i;
         end
      end
   end

   assign data_o  = hold_q;
   assign ready_o = (state_q == O_OFFER);
   assign idle_o  = hold_last_q && (state_q != O_IDLE);
   assign done_o  = done_q;

endmodule

// File: rtl/sample_packer.sv
// sample_packer: packs samples into chunks (first sample in the
// MSBs) and hands them to the parser one frame at a time.
module sample_packer
   import sample_packer_pkg::*;
#(
   parameter int SAMPLE_W    = sample_packer_pkg::SAMPLE_W,
   parameter int CHUNK_W     = sample_packer_pkg::CHUNK_W,
   parameter int FRAME_BYTES = sample_packer_pkg::FRAME_BYTES
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_start,
   input  logic [SAMPLE_W-1:0] sample_din,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic [CHUNK_W-1:0]  data_flat,
   output logic                data_ready,
   output logic                data_idle,
   input  logic                Parsar_busy,
   output logic                frame_active,
   output logic                frame_done
);

   localparam int NLANE  = CHUNK_W / SAMPLE_W;
   localparam int NCHUNK = FRAME_BYTES * 8 / CHUNK_W;
   localparam int LW     = (NLANE > 1) ? $clog2(NLANE) : 1;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [LW-1:0] LANE_LAST  = LW'(NLANE - 1);
   localparam logic [CW-1:0] CHUNK_LAST = CW'(NCHUNK - 1);

   logic [LW-1:0]      lane_q, lane_d;
   logic [CW-1:0]      chunk_q, chunk_d;
   logic               active_q, active_d;
   logic [CHUNK_W-1:0] asm_q, asm_d;
   logic               hold_valid;
   logic               accept;
   logic               load;

   assign sample_ready = active_q && !(lane_q == LANE_LAST && hold_valid);
   assign accept       = sample_valid && sample_ready;
   assign load         = accept && (lane_q == LANE_LAST);
   assign frame_active = active_q;

   always_comb begin
      lane_d   = lane_q;
      chunk_d  = chunk_q;
      active_d = active_q;
      asm_d    = asm_q;
      if (frame_start && !active_q) begin
         active_d = 1'b1;
         lane_d   = '0;
         chunk_d  = '0;
      end else if (accept) begin
         asm_d[CHUNK_W-1-int'(lane_q)*SAMPLE_W -: SAMPLE_W] = sample_din;
         lane_d = lane_q + LW'(1);
         if (load) begin
            lane_d  = '0;
            chunk_d = chunk_q + CW'(1);
            if (chunk_q == CHUNK_LAST) active_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane_q   <= '0;
         chunk_q  <= '0;
         active_q <= 1'b0;
         asm_q    <= '0;
      end else begin
         lane_q   <= lane_d;
         chunk_q  <= chunk_d;
         active_q <= active_d;
         asm_q    <= asm_d;
      end
   end

   chunk_offer_fsm #(
      .CHUNK_W (CHUNK_W)
   ) u_offer (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (load),
      .chunk_i      (asm_d),
      .last_i       (chunk_q == CHUNK_LAST),
      .busy_i       (Parsar_busy),
      .hold_valid_o (hold_valid),
      .data_o       (data_flat),
      .ready_o      (data_ready),
      .idle_o       (data_idle),
      .done_o       (frame_done)
   );

endmodule

// File: doc/sample_packer.md
Name: sample_packer

Overview:
- Upstream feeder for the output parser stage.
- Collects 16-bit samples into 128-bit chunks, one frame of FRAME_BYTES at a time.
- Presents each chunk on data_flat with the data_ready/Parsar_busy handshake and flags the last chunk of the frame with data_idle.
- Double-buffered (assembly register plus hold register), so sample intake continues while a chunk is in handshake.

Parameters:
- SAMPLE_W, 16: sample width. CHUNK_W must be an integer multiple of SAMPLE_W.
- CHUNK_W, 128: chunk width driven to the parser.
- FRAME_BYTES, 256: bytes per frame. Must be a multiple of CHUNK_W/8.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse that arms a frame; ignored while frame_active=1.
- sample_din  in  SAMPLE_W  sample data.
- sample_valid  in  1  sample_din is valid.
- sample_ready  out  1  the packer accepts a sample this cycle when sample_valid=1.
- data_flat  out  CHUNK_W  chunk to the parser; first sample of the chunk in the MSBs.
- data_ready  out  1  chunk offered.
- data_idle  out  1  offered chunk is the last of its frame.
- Parsar_busy  in  1  parser has taken the chunk and is serialising it.
- frame_active  out  1  frame armed and not all samples received.
- frame_done  out  1  one-cycle pulse when the last chunk's handshake completes.

Behaviour:
- Derived constants: LANES = CHUNK_W/SAMPLE_W (8); CHUNKS = FRAME_BYTES*8/CHUNK_W (16).
- Reset (rst_n=0 at a clock edge): all outputs 0 on the next cycle; lane and chunk counters cleared; hold register emptied. A partial chunk is discarded; the parser is reset concurrently.
- Arming: frame_start while frame_active=0 sets frame_active and clears the lane and chunk counters. Arming is allowed while the previous frame's last chunk is still draining.
- Intake: sample_ready = frame_active AND NOT (lane==LANES-1 AND hold_valid).
- Accept: an accepted sample is written to lane slot [CHUNK_W-1-lane*SAMPLE_W -: SAMPLE_W], then lane increments.
- Chunk complete: accepting lane LANES-1 copies the full chunk (including this sample) into the hold register in the same edge, sets hold_valid, wraps lane to 0 and increments chunk_cnt.
- Last chunk: hold_last = (chunk_cnt==CHUNKS-1). When the last chunk is loaded, frame_active clears on the same edge.
- Output FSM states:
  - O_IDLE: waits for hold_valid. data_ready=0.
  - O_OFFER: data_ready=1, data_flat=hold, data_idle=hold_last; data_flat and data_idle stable.
  - O_DRAIN: data_ready=0; data_flat held.
- Output FSM transitions:
  - O_IDLE -> O_OFFER on hold_valid=1.
  - O_OFFER -> O_DRAIN on the first cycle Parsar_busy=1 is sampled. data_ready drops the next cycle.
  - O_DRAIN -> O_IDLE on the first cycle Parsar_busy=0. This clears hold_valid. If hold_last, frame_done pulses for one cycle and data_idle returns to 0.
- Minimum gap between offers is one O_IDLE cycle. A new hold load may occur in the same edge that hold_valid clears.
- Backpressure: at most LANES-1 buffered samples plus one held chunk. When both are full, sample_ready=0; samples are never dropped or duplicated.
- sample_valid while not armed: no effect. frame_start while frame_active=1: ignored.
- Parsar_busy high in O_IDLE: ignored.

Decomposition:
- Shared package (shared with the parser): SAMPLE_W, CHUNK_W, FRAME_BYTES, the derived LANES/CHUNKS, and the output-FSM state enum {O_IDLE, O_OFFER, O_DRAIN}.
- One natural sub-module, chunk_offer_fsm:
  - Contains the hold register, the output FSM and frame_done.
  - Takes load/chunk/last from the intake logic and returns hold_valid.

Test Plan:
- Single frame: frame_start, then 128 samples 0x0000..0x007F, one per cycle; parser model raises busy 1 cycle after data_ready for 4 cycles.
  -> 16 chunks; first data_flat=0x0000_0001_0002_0003_0004_0005_0006_0007; last=0x0078_..._007F.
  -> data_idle=1 only on chunk 15; exactly one frame_done.
- Backpressure: samples offered every cycle, busy held 40 cycles per chunk.
  -> sample_ready falls after sample 15; output order is contiguous 0x0000..0x007F with no gaps or repeats.
- Unarmed/ignored inputs: sample_valid=1 with no frame_start -> sample_ready=0, data_ready stays 0. A second frame_start mid-frame -> no counter reset, still 16 chunks.
- Reset mid-frame: rst_n=0 for 1 cycle after 37 samples.
  -> next cycle all outputs 0. A new frame of 0x1000.. produces first chunk 0x1000..0x1007 and no stale data.
- Back-to-back frames: frame_start asserted the cycle after frame_active falls.
  -> frame 2's first chunk is offered only after frame 1's chunk 15 drains; frame_done pulses once per frame.
- Handshake timing: busy asserted 5 cycles after data_ready.
  -> data_flat/data_idle stable throughout; data_ready low exactly 1 cycle after busy is sampled high.
